full_adder: RTL and testbench
=============================

Name:
full_adder

Overview:
- Bit-level full adder, parameterizable into a WIDTH-bit ripple-carry adder built from chained full-adder cells.
- Basic arithmetic primitive of the ALU datapath.
- Default configuration is one bit with purely combinational outputs.
- An optional output register stage supports pipelined ALU use.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..32.
- REG_OUT, 0, 0 = combinational outputs; 1 = outputs registered on clk with one-cycle latency.

Ports:
- clk  input  1  clock; rising-edge active; used only when REG_OUT=1.
- rst_n  input  1  reset; synchronous, active-low; used only when REG_OUT=1.
- a  input  WIDTH  addend A, unsigned or two's complement.
- b  input  WIDTH  addend B.
- cin  input  1  carry in to bit 0.
- valid_in  input  1  qualifies a/b/cin for the registered path; tie high when unused.
- s  output  WIDTH  sum bits.
- cout  output  1  carry out of MSB.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- valid_out  output  1  qualifies s/cout/ovf.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Cell equations, per bit i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])
  - c[0] = cin; cout = c[WIDTH].
- Arithmetic: {cout, s} = a + b + cin, computed mod 2^(WIDTH+1), with no truncation of the carry.
- ovf = c[WIDTH-1] ^ c[WIDTH].
  - WIDTH=1: ovf = cin ^ cout.
- Carry chain: explicit ripple through per-bit cells; no lookahead required.

REG_OUT=0:
- s, cout and ovf are pure combinational functions of a, b and cin.
- They settle within the same evaluation step; zero cycle latency.
- valid_out = valid_in combinationally.
- clk and rst_n are ignored; there is no state.
- X/Z on any input bit propagates per standard 4-state semantics; no masking.

REG_OUT=1:
- At each rising clk with rst_n=1: s, cout and ovf capture the combinational results; valid_out <= valid_in.
- Registers load every cycle regardless of valid_in; valid_in only gates valid_out.
- At rising clk with rst_n=0: s=0, cout=0, ovf=0, valid_out=0.
- Reset dominates simultaneous input changes.
- Reset mid-operation discards the in-flight result; the first valid result appears one cycle after the first clock with rst_n=1 and valid_in=1.
- Latency is exactly 1 cycle; throughput is 1 operation per cycle; no backpressure.
- Before the first clock edge, outputs are undefined. Benches must apply reset first.

Wrap-around and boundaries:
- All-ones + all-ones + cin=1 gives s = all-ones, cout=1.
- all-zeros + all-zeros + cin=0 gives s=0, cout=0, ovf=0.
- Most-positive + 1 gives ovf=1, cout=0.

Test Plan:
- WIDTH=1, REG_OUT=0, apply 000,100,010,110,001,101,011,111 for (a,b,cin) at 100 ns spacing. Required (s,cout) = 00,10,10,01,10,01,01,11; return to 000 gives 00.
- WIDTH=1, REG_OUT=0, check ovf across the same sweep. Required ovf = cin^cout: 0,0,0,1,1,0,0,0.
- WIDTH=8, REG_OUT=0:
  - a=8'hFF, b=8'h01, cin=0 -> s=8'h00, cout=1, ovf=0.
  - a=8'h7F, b=8'h01, cin=0 -> s=8'h80, cout=0, ovf=1.
  - a=8'hFF, b=8'hFF, cin=1 -> s=8'hFF, cout=1.
- WIDTH=8, REG_OUT=1, sequence:
  - Hold rst_n=0 for 2 clocks -> all outputs 0.
  - Release reset, apply a=8'h12, b=8'h34, cin=1, valid_in=1 -> after exactly 1 rising edge, s=8'h47, cout=0, valid_out=1.
- WIDTH=8, REG_OUT=1, mid-stream reset: assert rst_n=0 for one cycle while valid_in=1 -> on that edge, outputs and valid_out go to 0; the next edge with rst_n=1 loads the current inputs.
- WIDTH=16, random: 1000 random a, b, cin in both REG_OUT modes -> {cout,s} equals a+b+cin; ovf matches the signed-overflow reference.

Source files
------------

// File: rtl/full_adder.sv
// Parameterizable ripple-carry adder built from chained full-adder cells.
// With REG_OUT=0 the sum, carry-out, signed overflow and valid flag are
// purely combinational; with REG_OUT=1 they are captured on the rising
// clock edge with a synchronous active-low reset, giving one cycle latency.
module full_adder #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             valid_in,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             valid_out
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  assign carry[0] = cin;

  // One full-adder cell per bit, rippling the carry upward with no lookahead.
  for (genvar i = 0; i < WIDTH; i++) begin : gen_cell
    assign sum_d[i]   = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  // Signed overflow is the disagreement between the carry into and out of
  // the MSB; for a one-bit adder the carry into the MSB is cin itself.
  assign cout_d = carry[WIDTH];
  assign ovf_d  = carry[WIDTH-1] ^ carry[WIDTH];

  if (REG_OUT) begin : gen_reg
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             valid_q;

    // Output stage loads every cycle; valid_in only qualifies the result,
    // and a low rst_n on the edge clears everything, discarding in-flight data.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sum_q   <= '0;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        cout_q  <= cout_d;
        ovf_q   <= ovf_d;
        valid_q <= valid_in;
      end
    end

    assign s         = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign valid_out = valid_q;
  end else begin : gen_comb
    // Clock and reset have no role in the combinational configuration.
    logic unusedClkRst;
    assign unusedClkRst = clk ^ rst_n;

    assign s         = sum_d;
    assign cout      = cout_d;
    assign ovf       = ovf_d;
    assign valid_out = valid_in;
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder in several configurations:
// one-bit and eight-bit combinational, eight-bit registered, and
// sixteen-bit in both combinational and registered form.
module tb_full_adder;

  logic clk;
  logic rst_n;

  // One-bit combinational instance
  logic a1, b1, cin1, vin1;
  logic s1, cout1, ovf1, vout1;

  // Eight-bit instances (combinational and registered share operands)
  logic [7:0] a8, b8;
  logic       cin8, vin8;
  logic [7:0] s8c, s8r;
  logic       cout8c, ovf8c, vout8c;
  logic       cout8r, ovf8r, vout8r;

  // Sixteen-bit instances (combinational and registered share operands)
  logic [15:0] a16, b16;
  logic        cin16, vin16;
  logic [15:0] s16c, s16r;
  logic        cout16c, ovf16c, vout16c;
  logic        cout16r, ovf16r, vout16r;

  int total;
  int bad;

  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) dutW1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .valid_in(vin1),
    .s(s1), .cout(cout1), .ovf(ovf1), .valid_out(vout1)
  );

  full_adder #(.WIDTH(8), .REG_OUT(1'b0)) dutW8c (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .valid_in(vin8),
    .s(s8c), .cout(cout8c), .ovf(ovf8c), .valid_out(vout8c)
  );

  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) dutW8r (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .valid_in(vin8),
    .s(s8r), .cout(cout8r), .ovf(ovf8r), .valid_out(vout8r)
  );

  full_adder #(.WIDTH(16), .REG_OUT(1'b0)) dutW16c (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16), .valid_in(vin16),
    .s(s16c), .cout(cout16c), .ovf(ovf16c), .valid_out(vout16c)
  );

  full_adder #(.WIDTH(16), .REG_OUT(1'b1)) dutW16r (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16), .valid_in(vin16),
    .s(s16r), .cout(cout16r), .ovf(ovf16r), .valid_out(vout16r)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts it, and counts and reports a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives the one-bit adder and checks sum, carry and overflow after 100 ns
  task automatic applyStimulus(input logic [2:0] abc, input logic [1:0] expSc,
                               input logic expOvf, input int step);
    a1   = abc[2];
    b1   = abc[1];
    cin1 = abc[0];
    #100;
    checkOutput($sformatf("w1_s_%0d", step),    32'(s1),    32'(expSc[1]));
    checkOutput($sformatf("w1_cout_%0d", step), 32'(cout1), 32'(expSc[0]));
    checkOutput($sformatf("w1_ovf_%0d", step),  32'(ovf1),  32'(expOvf));
  endtask

  initial begin
    logic [2:0]  sweepIn  [8];
    logic [1:0]  sweepSc  [8];
    logic        sweepOvf [8];
    logic [16:0] expSum;
    int          sa, sb, ssum;
    logic        expOvf16;

    total = 0;
    bad   = 0;

    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; vin1 = 1'b1;
    a8 = '0;   b8 = '0;   cin8 = 1'b0; vin8 = 1'b0;
    a16 = '0;  b16 = '0;  cin16 = 1'b0; vin16 = 1'b0;

    // One-bit truth-table sweep, (a,b,cin) order 000,100,010,110,001,101,011,111
    sweepIn  = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    sweepSc  = '{2'b00,  2'b10,  2'b10,  2'b01,  2'b10,  2'b01,  2'b01,  2'b11};
    sweepOvf = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b0};
    for (int i = 0; i < 8; i++) applyStimulus(sweepIn[i], sweepSc[i], sweepOvf[i], i);
    applyStimulus(3'b000, 2'b00, 1'b0, 8);
    checkOutput("w1_valid_hi", 32'(vout1), 32'd1);
    vin1 = 1'b0;
    #1;
    checkOutput("w1_valid_lo", 32'(vout1), 32'd0);

    // Registered instances: hold reset across two rising edges
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("w8r_rst_s",     32'(s8r),    32'h00);
    checkOutput("w8r_rst_cout",  32'(cout8r), 32'd0);
    checkOutput("w8r_rst_ovf",   32'(ovf8r),  32'd0);
    checkOutput("w8r_rst_valid", 32'(vout8r), 32'd0);
    checkOutput("w16r_rst_s",    32'(s16r),   32'h0000);

    // Eight-bit combinational boundaries (reset must not matter here)
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
    #1;
    checkOutput("w8c_wrap_s",    32'(s8c),    32'h00);
    checkOutput("w8c_wrap_cout", 32'(cout8c), 32'd1);
    checkOutput("w8c_wrap_ovf",  32'(ovf8c),  32'd0);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    #1;
    checkOutput("w8c_maxpos_s",    32'(s8c),    32'h80);
    checkOutput("w8c_maxpos_cout", 32'(cout8c), 32'd0);
    checkOutput("w8c_maxpos_ovf",  32'(ovf8c),  32'd1);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    #1;
    checkOutput("w8c_ones_s",    32'(s8c),    32'hFF);
    checkOutput("w8c_ones_cout", 32'(cout8c), 32'd1);
    checkOutput("w8c_ones_ovf",  32'(ovf8c),  32'd0);
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    #1;
    checkOutput("w8c_zero_s",    32'(s8c),    32'h00);
    checkOutput("w8c_zero_cout", 32'(cout8c), 32'd0);
    checkOutput("w8c_zero_ovf",  32'(ovf8c),  32'd0);
    checkOutput("w8r_rst_hold",  32'(vout8r), 32'd0);

    // Release reset and launch 0x12 + 0x34 + 1 with one-cycle latency
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; vin8 = 1'b1;
    #1;
    checkOutput("w8r_pre_edge_valid", 32'(vout8r), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("w8r_first_s",     32'(s8r),    32'h47);
    checkOutput("w8r_first_cout",  32'(cout8r), 32'd0);
    checkOutput("w8r_first_ovf",   32'(ovf8r),  32'd0);
    checkOutput("w8r_first_valid", 32'(vout8r), 32'd1);

    // valid_in low still loads the data but deasserts valid_out
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; vin8 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("w8r_novalid_s",     32'(s8r),    32'hFF);
    checkOutput("w8r_novalid_cout",  32'(cout8r), 32'd1);
    checkOutput("w8r_novalid_valid", 32'(vout8r), 32'd0);

    // Mid-stream reset for one cycle with valid_in high
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; vin8 = 1'b1; rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("w8r_midrst_s",     32'(s8r),    32'h00);
    checkOutput("w8r_midrst_cout",  32'(cout8r), 32'd0);
    checkOutput("w8r_midrst_ovf",   32'(ovf8r),  32'd0);
    checkOutput("w8r_midrst_valid", 32'(vout8r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("w8r_after_s",     32'(s8r),    32'h80);
    checkOutput("w8r_after_cout",  32'(cout8r), 32'd0);
    checkOutput("w8r_after_ovf",   32'(ovf8r),  32'd1);
    checkOutput("w8r_after_valid", 32'(vout8r), 32'd1);

    // Sixteen-bit random operands checked in both output modes
    vin16 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin16 = 1'($urandom_range(0, 1));
      expSum   = {1'b0, a16} + {1'b0, b16} + 17'(cin16);
      sa       = int'($signed(a16));
      sb       = int'($signed(b16));
      ssum     = sa + sb + int'(cin16);
      expOvf16 = (ssum > 32767) || (ssum < -32768);
      #1;
      checkOutput("w16c_sum", 32'({cout16c, s16c}), 32'(expSum));
      checkOutput("w16c_ovf", 32'(ovf16c), 32'(expOvf16));
      @(posedge clk);
      #1;
      checkOutput("w16r_sum",   32'({cout16r, s16r}), 32'(expSum));
      checkOutput("w16r_ovf",   32'(ovf16r),  32'(expOvf16));
      checkOutput("w16r_valid", 32'(vout16r), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
